// File: rtl/and_gate_bist.sv
// Self-test driver and response checker for the registered two-input AND cell.
// Optional first-failure capture outputs are enabled by defining AND_GATE_BIST_FAIL_CAPTURE_EN.
module and_gate_bist #(
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
  ,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
`endif
);

  // state | meaning
  // IDLE  | a=b=0, waiting for start
  // RUN   | driving vector idx[1:0] each cycle
  // DRAIN | a=b=0 while the last response is checked
  // DONE  | one-cycle done pulse, pass valid

  localparam int N     = 4 * NUM_PASSES;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic             exp_q;
  logic             exp_v;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
  logic [1:0]       exp_vec;
`endif

  assign idx_inc  = idx + IDX_W'(1);
  assign mismatch = exp_v && (y != exp_q);

  // saturating increment; never wraps
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != {ERR_W{1'b1}}))
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      exp_q     <= 1'b0;
      exp_v     <= 1'b0;
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
      exp_vec          <= 2'b00;
      first_fail_vec   <= 2'b00;
      first_fail_valid <= 1'b0;
`endif
    end else begin
      exp_q     <= a & b;
      exp_v     <= (state == RUN);
      done      <= 1'b0;
      err_count <= err_next;
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
      exp_vec <= {a, b};
      if (mismatch && !first_fail_valid) begin
        first_fail_vec   <= exp_vec;
        first_fail_valid <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            err_count <= '0;
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (idx == LAST_IDX) begin
            state <= DRAIN;
            a     <= 1'b0;
            b     <= 1'b0;
          end else begin
            idx    <= idx_inc;
            {a, b} <= idx_inc[1:0];
          end
        end
        DRAIN: begin
          // final response is checked on this edge, so pass uses err_next
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_bist.sv
// Bench for and_gate_bist: three instances with different NUM_PASSES/ERR_W, each
// driving a modelled cell whose truth table can be made faulty.
module tb_and_gate_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] st = 3'b000;
  logic [2:0] av, bv, busyv, donev, passv;
  logic [2:0] yv = 3'b000;
  logic [7:0] e0, e1;
  logic [1:0] e2;
  logic [3:0] lut [3];
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
  logic [1:0] ff0, ff1, ff2;
  logic [2:0] ffv;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_gate_bist #(.NUM_PASSES(1), .ERR_W(8)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .a(av[0]), .b(bv[0]), .y(yv[0]),
    .busy(busyv[0]), .done(donev[0]), .pass(passv[0]), .err_count(e0)
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
    , .first_fail_vec(ff0), .first_fail_valid(ffv[0])
`endif
  );

  and_gate_bist #(.NUM_PASSES(3), .ERR_W(8)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .a(av[1]), .b(bv[1]), .y(yv[1]),
    .busy(busyv[1]), .done(donev[1]), .pass(passv[1]), .err_count(e1)
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
    , .first_fail_vec(ff1), .first_fail_valid(ffv[1])
`endif
  );

  and_gate_bist #(.NUM_PASSES(2), .ERR_W(2)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .a(av[2]), .b(bv[2]), .y(yv[2]),
    .busy(busyv[2]), .done(donev[2]), .pass(passv[2]), .err_count(e2)
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
    , .first_fail_vec(ff2), .first_fail_valid(ffv[2])
`endif
  );

  // registered cell models: output is the truth-table entry for the sampled {a,b}
  always @(posedge clk) begin
    yv[0] <= lut[0][{av[0], bv[0]}];
    yv[1] <= lut[1][{av[1], bv[1]}];
    yv[2] <= lut[2][{av[2], bv[2]}];
  end

  function automatic int npf(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic int errmax(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic int errof(input int i);
    return (i == 0) ? int'(e0) : (i == 1) ? int'(e1) : int'(e2);
  endfunction

`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
  function automatic int ffof(input int i);
    return (i == 0) ? int'(ff0) : (i == 1) ? int'(ff1) : int'(ff2);
  endfunction
`endif

  // reference: a correct AND cell has truth table 4'b1000
  function automatic int model_mism(input logic [3:0] l, input int np);
    int cnt = 0;
    logic [3:0] good = 4'b1000;
    for (int v = 0; v < 4; v++)
      if (l[v] != good[v]) cnt++;
    return cnt * np;
  endfunction

  function automatic int model_first(input logic [3:0] l);
    logic [3:0] good = 4'b1000;
    for (int v = 0; v < 4; v++)
      if (l[v] != good[v]) return v;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_test(input int i, input logic [3:0] l, input int exp_err,
                          input int exp_pass, input int exp_ff, input int exp_ffv,
                          input string name);
    int cyc;
    int n;
    bit found;
    lut[i] = l;
    @(negedge clk);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    cyc = 1;
    n = 4 * npf(i);
    found = 1'b0;
    while (cyc <= n + 10 && !found) begin
      if (donev[i]) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({name, "_done_cycle"}, found ? cyc : -1, n + 2);
    if (found) begin
      chk({name, "_err_count"}, errof(i), exp_err);
      chk({name, "_pass"}, int'(passv[i]), exp_pass);
`ifdef AND_GATE_BIST_FAIL_CAPTURE_EN
      chk({name, "_ff_valid"}, int'(ffv[i]), exp_ffv);
      if (exp_ffv != 0) chk({name, "_ff_vec"}, ffof(i), exp_ff);
`endif
    end
    @(negedge clk);
  endtask

  typedef struct {
    int         inst;
    logic [3:0] l;
    int         exp_err;
    int         exp_pass;
    int         exp_ff;
    int         exp_ffv;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int dcount;
    int mism;
    logic [3:0] rl;
    int ri;

    tbl[0] = '{0, 4'b1000, 0, 1, 0, 0};
    tbl[1] = '{1, 4'b0000, 3, 0, 3, 1};
    tbl[2] = '{2, 4'b1111, 3, 0, 0, 1};
    tbl[3] = '{1, 4'b1000, 0, 1, 0, 0};
    tbl[4] = '{0, 4'b1001, 1, 0, 0, 1};
    tbl[5] = '{2, 4'b0000, 2, 0, 3, 1};
    tbl[6] = '{1, 4'b1111, 9, 0, 0, 1};
    tbl[7] = '{2, 4'b1010, 2, 0, 1, 1};

    for (int i = 0; i < 3; i++) lut[i] = 4'b1000;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_a", int'(av), 0);
    chk("rst_b", int'(bv), 0);
    chk("rst_busy", int'(busyv), 0);
    chk("rst_done", int'(donev), 0);
    chk("rst_pass", int'(passv), 0);
    chk("rst_err", int'(e0) + int'(e1) + int'(e2), 0);
    reset = 1'b0;
    @(negedge clk);

    // cycle-accurate good run on u0
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("seqA_ab_c%0d", c), int'({av[0], bv[0]}), (c <= 4) ? c - 1 : 0);
      chk($sformatf("seqA_busy_c%0d", c), int'(busyv[0]), (c <= 5) ? 1 : 0);
      chk($sformatf("seqA_done_c%0d", c), int'(donev[0]), (c == 6) ? 1 : 0);
      if (c == 6) chk("seqA_pass", int'(passv[0]), 1);
      @(negedge clk);
    end
    chk("seqA_busy_c7", int'(busyv[0]), 0);

    // table-driven tests
    for (int t = 0; t < 8; t++)
      run_test(tbl[t].inst, tbl[t].l, tbl[t].exp_err, tbl[t].exp_pass,
               tbl[t].exp_ff, tbl[t].exp_ffv, $sformatf("tbl%0d", t));

    // extra start pulses in cycles 2 and 6 are ignored
    lut[0] = 4'b1000;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 12; c++) begin
      if (donev[0]) dcount++;
      if (c == 7) chk("seqB_busy_c7", int'(busyv[0]), 0);
      st[0] = (c == 2 || c == 6);
      @(negedge clk);
    end
    st[0] = 1'b0;
    chk("seqB_done_count", dcount, 1);
    chk("seqB_busy_end", int'(busyv[0]), 0);
    chk("seqB_pass", int'(passv[0]), 1);

    // reset in cycle 3 of RUN aborts without a done pulse
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("seqC_ab", int'({av[0], bv[0]}), 0);
    chk("seqC_busy", int'(busyv[0]), 0);
    chk("seqC_pass", int'(passv[0]), 0);
    chk("seqC_err", int'(e0), 0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      if (donev != 3'b000) dcount++;
      @(negedge clk);
    end
    chk("seqC_no_done", dcount, 0);
    run_test(0, 4'b1000, 0, 1, 0, 0, "seqC_clean");

    // pass holds through a new test and updates at DONE
    run_test(0, 4'b0000, 1, 0, 3, 1, "seqD_t1");
    lut[0] = 4'b1000;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("seqD_err_cleared", int'(e0), 0);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("seqD_pass_c%0d", c), int'(passv[0]), (c == 6) ? 1 : 0);
      @(negedge clk);
    end

    // randomized faulty cells against the truth-table model
    for (int r = 0; r < 12; r++) begin
      ri = $urandom_range(0, 2);
      rl = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      mism = model_mism(rl, npf(ri));
      run_test(ri, rl, (mism > errmax(ri)) ? errmax(ri) : mism, (mism == 0) ? 1 : 0,
               model_first(rl), (mism != 0) ? 1 : 0, $sformatf("rnd%0d_i%0d", r, ri));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/and_gate_bist.md
Name: and_gate_bist

Overview:
- Self-test driver and response checker for the registered two-input AND cell.
- Sits on the opposite side of the cell's a/b/y interface: generates a and b, samples the registered y one cycle later, and compares against a locally computed expectation.
- Used for post-reset sanity and in-system self-test of the cell, including through the OpenROAD flow.

Parameters:
- NUM_PASSES, 1, number of full sweeps of the 4-vector set (legal range 1..255).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock shared with the cell under test.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a test; sampled only in IDLE.
- a  output  1  registered stimulus to cell input a.
- b  output  1  registered stimulus to cell input b.
- y  input  1  registered response from the cell (1-cycle latency).
- busy  output  1  high in RUN and DRAIN.
- done  output  1  single-cycle pulse at end of test.
- pass  output  1  result of last completed test; 1 iff err_count==0.
- err_count  output  ERR_W  mismatches in last or current test, saturating.

Behaviour:
- Reset (async, active-high) forces all state and outputs: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, vector counter=0, exp_q=0, exp_v=0.
- Reset asserted mid-test aborts immediately. No done pulse is produced. A later start begins a fresh test.
- FSM states and transitions:
  - IDLE: a=b=0. On the edge where start=1, go to RUN, clear err_count, clear vector counter.
  - RUN: each cycle, {a,b} = idx[1:0], where idx counts 0..4*NUM_PASSES-1. Vector order is 00,01,10,11, repeated. After the cycle driving idx = 4*NUM_PASSES-1, go to DRAIN.
  - DRAIN: a=b=0 for one cycle, so the final response is checked. Then go to DONE.
  - DONE: done=1 for exactly one cycle. pass is updated to (err_count==0). Return to IDLE.
- Expectation pipeline:
  - On each edge: exp_q <= a & b, and exp_v <= (state==RUN).
  - On each edge where exp_v=1: if y != exp_q, err_count increments.
  - A vector driven in cycle k is checked at the edge ending cycle k+1.
- Latency: with N = 4*NUM_PASSES and start sampled at edge 0:
  - RUN occupies cycles 1..N.
  - DRAIN is cycle N+1.
  - done is high in cycle N+2.
- err_count saturates at 2^ERR_W-1 and never wraps.
- start is ignored in RUN, DRAIN and DONE. A start during DONE is not queued.
- pass and err_count hold their values from the end of a test until the next accepted start. pass is also held during the new test and updates only in DONE.
- y is ignored whenever exp_v=0, including in IDLE and immediately after reset.
- Fully synchronous to clk apart from reset. No combinational path from y or start to any output.

Optional Feature:
- Macro: AND_GATE_BIST_FAIL_CAPTURE_EN.
- When defined, two extra outputs are added:
  - first_fail_vec (output, 2): the {a,b} vector, i.e. the exp pipeline's source vector, of the first mismatch in the current test.
  - first_fail_valid (output, 1): set on the first mismatch.
- Both outputs are cleared on reset and on an accepted start.
- Each is set once and then held until cleared. Later mismatches never overwrite them.
- When not defined, these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Good cell, NUM_PASSES=1: reset, then a start pulse → a/b sequence 00,01,10,11 in cycles 1-4, done in cycle 6, pass=1, err_count=0.
- y tied to 0 (stuck-at-0), NUM_PASSES=3 → err_count=3, pass=0. With the macro: first_fail_vec=2'b11, first_fail_valid=1.
- y tied to 1 (stuck-at-1), NUM_PASSES=2, ERR_W=2 → 6 mismatches saturate to err_count=3, pass=0. With the macro: first_fail_vec=2'b00.
- Good cell, extra start pulses in cycles 2 and 6 after the first start → a single test runs, one done pulse only, pass=1, busy low again in cycle 7.
- Reset asserted in cycle 3 of RUN, then released → all outputs 0 asynchronously, no done pulse. A following start gives a full clean test with pass=1.
- Test 1 with stuck-at-0 (pass=0, err_count=1), then test 2 with a good cell → err_count cleared at start, pass holds 0 until DONE, then becomes 1.
